// File: rtl/responder_arbiter.sv
// Four-player quiz responder controller: arms an answer window, counts seconds down,
// grants the first press and pulses the beeper. Optional early-press fouls: FOUL_DETECT_EN.
module responder_arbiter #(
  parameter int ANSWER_SEC = 20,
  parameter int CNT_W      = 5,
  parameter int BEEP_CYC   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_start,
  input  logic             host_clr,
  input  logic [3:0]       buzz,
  input  logic             sec_tick,
  output logic [1:0]       state_o,
  output logic [3:0]       winner,
  output logic             winner_valid,
  output logic [CNT_W-1:0] timer_val,
  output logic             timeout,
  output logic             beep
`ifdef FOUL_DETECT_EN
  ,
  output logic [3:0]       foul
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_LOCKED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam int BW = $clog2(BEEP_CYC + 1);
  localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(ANSWER_SEC);
  localparam logic [BW-1:0]    BEEP_LOAD  = BW'(BEEP_CYC);

  state_t           state_q, state_d;
  logic [3:0]       buzz_q;
  logic [3:0]       winner_q, winner_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [BW-1:0]    beep_cnt_q, beep_cnt_d;
  logic [3:0]       foul_q, foul_d;
  logic [3:0]       press, press_m, grant;

  // A button already held when the window arms has no rising edge, so it never counts.
  assign press = buzz & ~buzz_q;

`ifdef FOUL_DETECT_EN
  assign press_m = press & ~foul_q;
  assign foul    = foul_q;
`else
  assign press_m = press;
`endif

  // Isolate the lowest set bit: player 0 wins ties.
  assign grant = press_m & (~press_m + 4'd1);

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    timer_d    = timer_q;
    foul_d     = foul_q;
    beep_cnt_d = (beep_cnt_q != '0) ? beep_cnt_q - 1'b1 : '0;
    if (host_clr) begin
      state_d    = S_IDLE;
      winner_d   = '0;
      timer_d    = TIMER_LOAD;
      foul_d     = '0;
      beep_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_d = TIMER_LOAD;
`ifdef FOUL_DETECT_EN
          foul_d  = foul_q | press;
`endif
          if (host_start) state_d = S_ARMED;
        end
        S_ARMED: begin
          // A press on the same edge as the final tick takes priority over timeout.
          if (press_m != 4'd0) begin
            state_d    = S_LOCKED;
            winner_d   = grant;
            beep_cnt_d = BEEP_LOAD;
          end else if (sec_tick) begin
            if (timer_q <= CNT_W'(1)) begin
              timer_d    = '0;
              state_d    = S_TIMEOUT;
              beep_cnt_d = BEEP_LOAD;
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      buzz_q     <= '0;
      winner_q   <= '0;
      timer_q    <= TIMER_LOAD;
      beep_cnt_q <= '0;
      foul_q     <= '0;
    end else begin
      state_q    <= state_d;
      buzz_q     <= buzz;
      winner_q   <= winner_d;
      timer_q    <= timer_d;
      beep_cnt_q <= beep_cnt_d;
      foul_q     <= foul_d;
    end
  end

`ifndef FOUL_DETECT_EN
  logic unused_foul;
  assign unused_foul = ^foul_q;
`endif

  assign state_o      = state_q;
  assign winner       = winner_q;
  assign winner_valid = (state_q == S_LOCKED);
  assign timer_val    = timer_q;
  assign timeout      = (state_q == S_TIMEOUT);
  assign beep         = (beep_cnt_q != '0);

endmodule

// File: tb/tb_responder_arbiter.sv
// Directed bench for responder_arbiter with ANSWER_SEC=3, BEEP_CYC=8.
module tb_responder_arbiter;

  localparam int CNT_W = 5;

  logic             clk;
  logic             rst_n;
  logic             host_start;
  logic             host_clr;
  logic [3:0]       buzz;
  logic             sec_tick;
  logic [1:0]       state_o;
  logic [3:0]       winner;
  logic             winner_valid;
  logic [CNT_W-1:0] timer_val;
  logic             timeout;
  logic             beep;
`ifdef FOUL_DETECT_EN
  logic [3:0]       foul;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_t;
  int beep_len;
  logic [3:0] exp_w4;
  logic [1:0] exp_s4;

  responder_arbiter #(.ANSWER_SEC(3), .CNT_W(CNT_W), .BEEP_CYC(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_start   (host_start),
    .host_clr     (host_clr),
    .buzz         (buzz),
    .sec_tick     (sec_tick),
    .state_o      (state_o),
    .winner       (winner),
    .winner_valid (winner_valid),
    .timer_val    (timer_val),
    .timeout      (timeout),
    .beep         (beep)
`ifdef FOUL_DETECT_EN
    ,
    .foul         (foul)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge, outputs sampled there too
  task automatic pulse_start();
    @(negedge clk); host_start = 1'b1;
    @(negedge clk); host_start = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); host_clr = 1'b1;
    @(negedge clk); host_clr = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk); sec_tick = 1'b1;
    @(negedge clk); sec_tick = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk); buzz = b;
    @(negedge clk); buzz = 4'd0;
  endtask

  initial begin
    rst_n = 1'b0; host_start = 1'b0; host_clr = 1'b0; buzz = 4'd0; sec_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_winner", winner, 0);
    chk("rst_wvalid", winner_valid, 0);
    chk("rst_timer", timer_val, 3);
    chk("rst_timeout", timeout, 0);
    chk("rst_beep", beep, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single press before any tick
    pulse_start();
    chk("t1_armed", state_o, 1);
    press(4'b0100);
    chk("t1_state", state_o, 2);
    chk("t1_winner", winner, 4'b0100);
    chk("t1_wvalid", winner_valid, 1);
    chk("t1_timer", timer_val, 3);
    beep_len = 0;
    for (int i = 0; i < 12; i++) begin
      if (beep) beep_len++;
      @(negedge clk);
    end
    chk("t1_beep_len", beep_len, 8);
    pulse_clr();
    chk("t1_clr_state", state_o, 0);

    // 2: tie between players 1 and 3
    pulse_start();
    press(4'b1010);
    chk("t2_winner", winner, 4'b0010);
    chk("t2_state", state_o, 2);
    pulse_clr();
    chk("t2_clr_winner", winner, 0);
    chk("t2_clr_state", state_o, 0);
    chk("t2_clr_timer", timer_val, 3);
    chk("t2_clr_wvalid", winner_valid, 0);

    // 3: timeout with no press; host_start ignored while armed
    exp_q.push_back(5'd2); exp_q.push_back(5'd1); exp_q.push_back(5'd0);
    pulse_start();
    tick();
    exp_t = exp_q.pop_front();
    chk("t3_tick1", timer_val, exp_t);
    pulse_start();
    chk("t3_restart_state", state_o, 1);
    chk("t3_restart_timer", timer_val, 2);
    tick();
    exp_t = exp_q.pop_front();
    chk("t3_tick2", timer_val, exp_t);
    tick();
    exp_t = exp_q.pop_front();
    chk("t3_tick3", timer_val, exp_t);
    chk("t3_state", state_o, 3);
    chk("t3_timeout", timeout, 1);
    chk("t3_beep", beep, 1);
    press(4'b0001);
    chk("t3_late_winner", winner, 0);
    chk("t3_late_state", state_o, 3);
    tick();
    chk("t3_no_wrap", timer_val, 0);
    pulse_clr();
    chk("t3_clr_timeout", timeout, 0);
    chk("t3_clr_timer", timer_val, 3);

    // 4: button held through arming, then re-pressed
    @(negedge clk); buzz = 4'b0001;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("t4_held_state", state_o, 1);
    chk("t4_held_winner", winner, 0);
    buzz = 4'd0;
    @(negedge clk);
    press(4'b0001);
`ifdef FOUL_DETECT_EN
    exp_w4 = 4'b0000; exp_s4 = 2'd1;
`else
    exp_w4 = 4'b0001; exp_s4 = 2'd2;
`endif
    chk("t4_repress_winner", winner, exp_w4);
    chk("t4_repress_state", state_o, exp_s4);
    pulse_clr();

    // 5: press and final tick on the same edge
    pulse_start();
    tick();
    tick();
    chk("t5_pre_timer", timer_val, 1);
    @(negedge clk); sec_tick = 1'b1; buzz = 4'b0100;
    @(negedge clk); sec_tick = 1'b0; buzz = 4'd0;
    chk("t5_state", state_o, 2);
    chk("t5_timer", timer_val, 1);
    chk("t5_timeout", timeout, 0);
    pulse_clr();

    // host_clr and host_start together
    pulse_start();
    @(negedge clk); host_clr = 1'b1; host_start = 1'b1;
    @(negedge clk); host_clr = 1'b0; host_start = 1'b0;
    chk("clr_start_state", state_o, 0);

`ifdef FOUL_DETECT_EN
    // 6: early press fouls player 0
    press(4'b0001);
    chk("t6_foul", foul, 4'b0001);
    pulse_start();
    press(4'b0011);
    chk("t6_foul_kept", foul, 4'b0001);
    chk("t6_winner", winner, 4'b0010);
    pulse_clr();
    chk("t6_clr_foul", foul, 0);
`endif

    // asynchronous reset mid-ARMED
    pulse_start();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_armed_state", state_o, 0);
    chk("arst_armed_timer", timer_val, 3);
    @(negedge clk); rst_n = 1'b1;

    // asynchronous reset while locked and beeping
    pulse_start();
    press(4'b1000);
    chk("arst_pre_beep", beep, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lock_state", state_o, 0);
    chk("arst_lock_winner", winner, 0);
    chk("arst_lock_wvalid", winner_valid, 0);
    chk("arst_lock_beep", beep, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/responder_arbiter.md
Name: responder_arbiter

Overview:
Controller for the four-player quiz responder.
- Arms the answer window on host command and runs a seconds countdown driven by the one-second tick from the team's clock divider.
- Grants the buzzer to the first player who presses and freezes the timer.
- Drives the winner, timer display value, timeout flag and a beeper pulse for the display and sounder logic.

Parameters:
ANSWER_SEC, 20, countdown start value in seconds; must be at least 1 and fit in CNT_W.
CNT_W, 5, width of the timer counter and timer_val.
BEEP_CYC, 8, length of the beep pulse in clk cycles; must be at least 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
host_start  input  1  one-cycle pulse: arm the answer window
host_clr  input  1  one-cycle pulse: return to IDLE and clear all results
buzz  input  4  player buttons, already synchronized and debounced, active-high level
sec_tick  input  1  one-cycle enable pulse, once per second, from the clock divider
state_o  output  2  current state: 0 IDLE, 1 ARMED, 2 LOCKED, 3 TIMEOUT
winner  output  4  one-hot granted player; 0 when no player is granted
winner_valid  output  1  high while in LOCKED
timer_val  output  CNT_W  remaining seconds
timeout  output  1  high while in TIMEOUT
beep  output  1  pulse on grant and on timeout
foul  output  4  per-player early-press flags; present only with the optional feature

Behaviour:
- Reset is asynchronous on rst_n low, active-low. During reset:
  - state is IDLE;
  - winner, winner_valid, timeout, beep and foul are 0;
  - timer_val is ANSWER_SEC;
  - the buzz history register is 0.
- All other logic updates on the rising edge of clk.
- Press detection:
  - buzz_d[i] registers buzz[i] every cycle.
  - press[i] = buzz[i] & ~buzz_d[i].
  - A button that is already held when the window arms never counts as a press.
- IDLE:
  - timer_val holds ANSWER_SEC.
  - host_start moves the block to ARMED on the next edge.
- ARMED:
  - Each sec_tick decrements timer_val by 1.
  - At the edge where timer_val is 1 and sec_tick is high, timer_val becomes 0, the block moves to TIMEOUT and timeout goes high.
  - At the first edge where any press[i] is high:
    - the block moves to LOCKED;
    - winner takes the one-hot of the lowest-index pressing player (player 0 has the highest priority on a tie);
    - winner_valid goes high at the same edge;
    - timer_val freezes at its current value.
  - A press and a final sec_tick at the same edge: the press wins. The block goes to LOCKED and timer_val stays 1.
  - A host_start received while ARMED is ignored.
- LOCKED and TIMEOUT:
  - Both hold until host_clr.
  - Presses and sec_tick are ignored.
  - A host_start is ignored.
- host_clr in any state:
  - moves the block to IDLE and reloads timer_val with ANSWER_SEC;
  - clears winner, winner_valid and timeout;
  - clears foul.
- host_clr and host_start in the same cycle: host_clr wins and the block ends in IDLE.
- Beep:
  - On entry to LOCKED or TIMEOUT, beep goes high for exactly BEEP_CYC cycles, timed by an internal down-counter.
  - host_clr terminates an active beep immediately.
- timer_val never wraps below 0 and never exceeds ANSWER_SEC.
- Output latency: state_o, winner, winner_valid, timer_val and timeout are all registered, with 1 cycle of latency from the causing edge.

Optional Feature:
Macro: FOUL_DETECT_EN.
- Defined:
  - A press[i] in IDLE sets foul[i]; the flag stays set until host_clr or reset.
  - In ARMED, any player with foul[i] set is masked from arbitration.
  - If all four players are fouled, the window can only end in TIMEOUT.
- Undefined:
  - The foul port is absent.
  - Presses in IDLE are ignored.
  - No masking is applied.

Test Plan:
1. Set ANSWER_SEC=3. Pulse host_start, then pulse buzz[2] before any tick. Expected: state_o=2, winner=4'b0100, winner_valid=1, timer_val=3, beep high for 8 cycles.
2. buzz[1] and buzz[3] rise on the same cycle while ARMED. Expected: winner=4'b0010. Then host_clr. Expected: winner=0, state_o=0, timer_val=ANSWER_SEC.
3. Set ANSWER_SEC=3, pulse host_start and give 3 sec_ticks with no press. Expected: timer_val steps 2, 1, 0; timeout=1; state_o=3; beep asserted; a later buzz[0] leaves winner=0.
4. Hold buzz[0] high from IDLE through host_start, then release and re-press it. Expected: no grant while held; grant to player 0 on the re-press.
5. With timer_val=1, assert sec_tick and press[2] at the same edge. Expected: state_o=2, timer_val=1, timeout=0.
6. With FOUL_DETECT_EN defined: press buzz[0] in IDLE, then host_start, then buzz[0] and buzz[1] rise together. Expected: foul=4'b0001, winner=4'b0010. Also: assert rst_n low mid-ARMED. Expected: all outputs reset immediately, asynchronously.
